disp_layer: RTL

- Parametrised successor to the single-paddle pong renderer.
- Composites N paddles, the ball, a two-digit score and a centre net over the vga timing counters.
- Pipeline is 2 stages, with hsync/vsync delayed to stay aligned with colour.
- Object positions are frame-latched so there is no tearing; score can blink; colour depth is configurable.
- Sits between vga (hcnt/vcnt/syncs) and the pin drivers.

---
 rtl/disp_pkg.sv | 49 ++++
 rtl/disp_rect_hit.sv | 31 +++
 rtl/disp_layer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared types and constant tables for the pong display compositor.
// Font rows are 3 bits wide, bit 2 is the leftmost font column.
package disp_pkg;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
   } pos_t;

   localparam int SCORE_XL = 280;
   localparam int SCORE_XR = 348;
   localparam int SCORE_Y  = 16;
   localparam int DIGIT_W  = 12;
   localparam int DIGIT_H  = 20;

   localparam logic [2:0] FONT [16][5] = '{
      '{3'b111, 3'b101, 3'b101, 3'b101, 3'b111},
      '{3'b010, 3'b110, 3'b010, 3'b010, 3'b111},
      '{3'b111, 3'b001, 3'b111, 3'b100, 3'b111},
      '{3'b111, 3'b001, 3'b111, 3'b001, 3'b111},
      '{3'b101, 3'b101, 3'b111, 3'b001, 3'b001},
      '{3'b111, 3'b100, 3'b111, 3'b001, 3'b111},
      '{3'b111, 3'b100, 3'b111, 3'b101, 3'b111},
      '{3'b111, 3'b001, 3'b001, 3'b001, 3'b001},
      '{3'b111, 3'b101, 3'b111, 3'b101, 3'b111},
      '{3'b111, 3'b101, 3'b111, 3'b001, 3'b111},
      '{3'b010, 3'b101, 3'b111, 3'b101, 3'b101},
      '{3'b110, 3'b101, 3'b110, 3'b101, 3'b110},
      '{3'b011, 3'b100, 3'b100, 3'b100, 3'b011},
      '{3'b110, 3'b101, 3'b101, 3'b101, 3'b110},
      '{3'b111, 3'b100, 3'b111, 3'b100, 3'b111},
      '{3'b111, 3'b100, 3'b111, 3'b100, 3'b100}
   };

   // {r,g,b} on/off per paddle: red, cyan, magenta, yellow
   localparam logic [2:0] PAD_COLOUR [4] = '{3'b100, 3'b011, 3'b101, 3'b110};

   function automatic logic font_px(input logic [3:0] d, input logic [2:0] row,
                                    input logic [1:0] col);
      logic [2:0] bits;
      bits = FONT[d][row];
      case (col)
         2'd0:    return bits[2];
         2'd1:    return bits[1];
         default: return bits[0];
      endcase
   endfunction

endpackage

// File: rtl/disp_rect_hit.sv
// Registered rectangle hit test: x <= h < x+W and y <= v < y+H.
// Right/bottom edges are formed in 11 bits so objects near 1023 clip instead of wrapping.
module disp_rect_hit
   import disp_pkg::*;
#(
   parameter int W = 8,
   parameter int H = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] h,
   input  logic [9:0] v,
   input  pos_t       pos,
   output logic       hit
);

   logic [10:0] xe;
   logic [10:0] ye;
   logic        hit_c;

   assign xe    = {1'b0, pos.x} + 11'(W);
   assign ye    = {1'b0, pos.y} + 11'(H);
   assign hit_c = (h >= pos.x) && ({1'b0, h} < xe) &&
                  (v >= pos.y) && ({1'b0, v} < ye);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) hit <= 1'b0;
      else      hit <= hit_c;
   end

endmodule

// File: rtl/disp_layer.sv
// Two-stage pong compositor: paddles, ball, two-digit score and centre net over vga counters.
// Object positions are shadowed once per frame so a frame never tears.
module disp_layer
   import disp_pkg::*;
#(
   parameter int NPADDLE      = 2,
   parameter int PAD_W        = 8,
   parameter int PAD_H        = 48,
   parameter int BALL_SZ      = 8,
   parameter int CDEPTH       = 1,
   parameter int H_ACTIVE     = 640,
   parameter int V_ACTIVE     = 480,
   parameter int BLINK_FRAMES = 30
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [9:0]             hcnt,
   input  logic [9:0]             vcnt,
   input  logic                   hsync_in,
   input  logic                   vsync_in,
   input  logic [19:0]            ball,
   input  logic [20*NPADDLE-1:0]  ppos,
   input  logic [7:0]             score,
   input  logic                   blink,
   output logic [CDEPTH-1:0]      r,
   output logic [CDEPTH-1:0]      g,
   output logic [CDEPTH-1:0]      b,
   output logic                   hsync,
   output logic                   vsync,
   output logic                   draw,
   output logic                   frame_tick
);

   localparam int            BW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
   localparam logic [9:0]    NET_L      = 10'(H_ACTIVE / 2 - 1);
   localparam logic [9:0]    NET_R      = 10'(H_ACTIVE / 2);

   pos_t                  ball_sh;
   logic [20*NPADDLE-1:0] ppos_sh;
   logic [7:0]            score_sh;
   logic                  valid;
   logic [BW-1:0]         bcnt;
   logic                  bhide;
   logic                  latch;

   assign latch = (hcnt == 10'd0) && (vcnt == 10'(V_ACTIVE));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ball_sh    <= '0;
         ppos_sh    <= '0;
         score_sh   <= '0;
         valid      <= 1'b0;
         bcnt       <= '0;
         bhide      <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= latch;
         if (latch) begin
            ball_sh  <= ball;
            ppos_sh  <= ppos;
            score_sh <= score;
            valid    <= 1'b1;
            if (bcnt == BLINK_LAST) begin
               bcnt  <= '0;
               bhide <= ~bhide;
            end else begin
               bcnt <= bcnt + 1'b1;
            end
         end
      end
   end

   // ---- stage 1: active flag, per-layer hits, font lookup ----
   logic               act_c;
   logic               vin_c;
   logic               inl_c;
   logic               inr_c;
   logic               score_c;
   logic               net_c;
   logic [2:0]         row_c;
   logic [1:0]         coll_c;
   logic [1:0]         colr_c;

   logic               act_p1;
   logic               vld_p1;
   logic               score_p1;
   logic               net_p1;
   logic               hs_p1;
   logic               vs_p1;
   logic               ball_hit_p1;
   logic [NPADDLE-1:0] pad_hit_p1;

   assign act_c = (hcnt < 10'(H_ACTIVE)) && (vcnt < 10'(V_ACTIVE));
   assign vin_c = (vcnt >= 10'(SCORE_Y)) && (vcnt < 10'(SCORE_Y + DIGIT_H));
   assign inl_c = vin_c && (hcnt >= 10'(SCORE_XL)) && (hcnt < 10'(SCORE_XL + DIGIT_W));
   assign inr_c = vin_c && (hcnt >= 10'(SCORE_XR)) && (hcnt < 10'(SCORE_XR + DIGIT_W));

   // Digit origins are multiples of 4, so font coordinates come straight from counter bits.
   assign row_c  = vcnt[4:2] - 3'(SCORE_Y / 4);
   assign coll_c = hcnt[3:2] - 2'(SCORE_XL / 4);
   assign colr_c = hcnt[3:2] - 2'(SCORE_XR / 4);

   assign score_c = !(blink && bhide) &&
                    ((inl_c && font_px(score_sh[7:4], row_c, coll_c)) ||
                     (inr_c && font_px(score_sh[3:0], row_c, colr_c)));
   assign net_c   = ((hcnt == NET_L) || (hcnt == NET_R)) && !vcnt[3];

   disp_rect_hit #(.W(BALL_SZ), .H(BALL_SZ)) u_ball (
      .clk (clk),
      .rst (rst),
      .h   (hcnt),
      .v   (vcnt),
      .pos (ball_sh),
      .hit (ball_hit_p1)
   );

   for (genvar i = 0; i < NPADDLE; i++) begin : g_pad
      disp_rect_hit #(.W(PAD_W), .H(PAD_H)) u_pad (
         .clk (clk),
         .rst (rst),
         .h   (hcnt),
         .v   (vcnt),
         .pos (ppos_sh[20*i +: 20]),
         .hit (pad_hit_p1[i])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         act_p1   <= 1'b0;
         vld_p1   <= 1'b0;
         score_p1 <= 1'b0;
         net_p1   <= 1'b0;
         hs_p1    <= 1'b1;
         vs_p1    <= 1'b1;
      end else begin
         act_p1   <= act_c;
         vld_p1   <= valid;
         score_p1 <= score_c;
         net_p1   <= net_c;
         hs_p1    <= hsync_in;
         vs_p1    <= vsync_in;
      end
   end

   // ---- stage 2: priority mux to colour and draw ----
   logic [2:0] col_c;
   logic       hit_c;

   always_comb begin
      col_c = 3'b000;
      hit_c = 1'b0;
      if (net_p1) begin
         col_c = 3'b001;
         hit_c = 1'b1;
      end
      if (score_p1) begin
         col_c = 3'b010;
         hit_c = 1'b1;
      end
      for (int i = NPADDLE - 1; i >= 0; i--) begin
         if (pad_hit_p1[i]) begin
            col_c = PAD_COLOUR[i];
            hit_c = 1'b1;
         end
      end
      if (ball_hit_p1) begin
         col_c = 3'b111;
         hit_c = 1'b1;
      end
      if (!(act_p1 && vld_p1)) begin
         col_c = 3'b000;
         hit_c = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r     <= '0;
         g     <= '0;
         b     <= '0;
         draw  <= 1'b0;
         hsync <= 1'b1;
         vsync <= 1'b1;
      end else begin
         r     <= {CDEPTH{col_c[2]}};
         g     <= {CDEPTH{col_c[1]}};
         b     <= {CDEPTH{col_c[0]}};
         draw  <= hit_c;
         hsync <= hs_p1;
         vsync <= vs_p1;
      end
   end

endmodule
